rf_write_arbiter: RTL and testbench

- Shares the register file's single write port between the pipeline write-back stage and a long-latency unit (LU, e.g. multiply/divide or a miss-return path).
- Write-back has fixed priority. LU results are queued in a small FIFO and drained into idle write-back slots.
- An age counter forces a pipeline stall when a queued result waits too long.
- Exports a pending-write lookup for the hazard unit.
- Sits between WB/LU and the register file.

---
 rtl/rf_write_arbiter.sv | 156 +++++++++++++++
 tb/tb_rf_write_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: write-back has fixed priority, long-latency
// results wait in a small FIFO and drain into idle slots, with an age-driven stall.
module rf_write_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  WB_reg_write_address_i,
  input  logic [31:0] WB_reg_write_data_i,
  input  logic        WB_ctrl_reg_write_i,
  input  logic        LU_valid_i,
  input  logic [4:0]  LU_rd_i,
  input  logic [31:0] LU_data_i,
  output logic        LU_ready_o,
  output logic [4:0]  RF_write_address_o,
  output logic [31:0] RF_write_data_o,
  output logic        RF_write_enable_o,
  output logic        stall_o,
  input  logic [4:0]  pend_rd_query_i,
  output logic        pend_hit_o
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = AW + 1;
  localparam int AGEW = $clog2(MAX_WAIT + 1);

  logic [4:0]      rd_q    [DEPTH];
  logic [4:0]      rd_d    [DEPTH];
  logic [31:0]     data_q  [DEPTH];
  logic [31:0]     data_d  [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] kill_q, kill_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AGEW-1:0] age_q, age_d;
  logic            stall_q, stall_d;

  logic wb_w, full, empty, accept, push, pop;
  logic head_killed, head_live;

  assign wb_w        = WB_ctrl_reg_write_i && (WB_reg_write_address_i != 5'd0);
  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign accept      = LU_valid_i && !full;
  // r0 results complete the handshake but are dropped here.
  assign push        = accept && (LU_rd_i != 5'd0);
  assign head_killed = !empty && kill_q[rd_ptr_q];
  assign head_live   = !empty && !kill_q[rd_ptr_q];
  // A killed head never uses the port, so it retires even under write-back.
  assign pop         = head_killed || (head_live && !wb_w);

  assign LU_ready_o  = !full;
  assign stall_o     = stall_q;

  always_comb begin
    RF_write_enable_o  = 1'b0;
    RF_write_address_o = 5'd0;
    RF_write_data_o    = 32'd0;
    if (!rst_i) begin
      if (wb_w) begin
        RF_write_enable_o  = 1'b1;
        RF_write_address_o = WB_reg_write_address_i;
        RF_write_data_o    = WB_reg_write_data_i;
      end else if (head_live) begin
        RF_write_enable_o  = 1'b1;
        RF_write_address_o = rd_q[rd_ptr_q];
        RF_write_data_o    = data_q[rd_ptr_q];
      end
    end
  end

  always_comb begin
    pend_hit_o = 1'b0;
    if (!rst_i && (pend_rd_query_i != 5'd0)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && !kill_q[i] && (rd_q[i] == pend_rd_query_i)) pend_hit_o = 1'b1;
      end
    end
  end

  always_comb begin
    rd_d     = rd_q;
    data_d   = data_q;
    valid_d  = valid_q;
    kill_d   = kill_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    age_d    = age_q;
    stall_d  = 1'b0;

    // Write-back is younger in program order, so it supersedes queued writes.
    if (wb_w) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && (rd_q[i] == WB_reg_write_address_i)) kill_d[i] = 1'b1;
      end
    end

    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      kill_d[rd_ptr_q]  = 1'b0;
      rd_ptr_d          = rd_ptr_q + AW'(1);
    end

    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      rd_d[wr_ptr_q]    = LU_rd_i;
      data_d[wr_ptr_q]  = LU_data_i;
      kill_d[wr_ptr_q]  = wb_w && (LU_rd_i == WB_reg_write_address_i);
      wr_ptr_d          = wr_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (empty || pop) begin
      age_d = '0;
    end else if (age_q != AGEW'(MAX_WAIT)) begin
      age_d = age_q + AGEW'(1);
    end

    stall_d = !empty && !pop && (age_q == AGEW'(MAX_WAIT));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= 5'd0;
        data_q[i] <= 32'd0;
      end
      valid_q  <= '0;
      kill_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      age_q    <= '0;
      stall_q  <= 1'b0;
    end else begin
      rd_q     <= rd_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      kill_q   <= kill_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      age_q    <= age_d;
      stall_q  <= stall_d;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter (DEPTH=2, MAX_WAIT=8).
module tb_rf_write_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  WB_reg_write_address_i;
  logic [31:0] WB_reg_write_data_i;
  logic        WB_ctrl_reg_write_i;
  logic        LU_valid_i;
  logic [4:0]  LU_rd_i;
  logic [31:0] LU_data_i;
  logic        LU_ready_o;
  logic [4:0]  RF_write_address_o;
  logic [31:0] RF_write_data_o;
  logic        RF_write_enable_o;
  logic        stall_o;
  logic [4:0]  pend_rd_query_i;
  logic        pend_hit_o;

  int checks = 0;
  int errors = 0;

  rf_write_arbiter #(.DEPTH(2), .MAX_WAIT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .WB_reg_write_address_i(WB_reg_write_address_i),
    .WB_reg_write_data_i(WB_reg_write_data_i),
    .WB_ctrl_reg_write_i(WB_ctrl_reg_write_i),
    .LU_valid_i(LU_valid_i), .LU_rd_i(LU_rd_i), .LU_data_i(LU_data_i),
    .LU_ready_o(LU_ready_o),
    .RF_write_address_o(RF_write_address_o),
    .RF_write_data_o(RF_write_data_o),
    .RF_write_enable_o(RF_write_enable_o),
    .stall_o(stall_o),
    .pend_rd_query_i(pend_rd_query_i), .pend_hit_o(pend_hit_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    WB_ctrl_reg_write_i = en; WB_reg_write_address_i = a; WB_reg_write_data_i = d;
  endtask

  task automatic set_lu(input logic v, input logic [4:0] a, input logic [31:0] d);
    LU_valid_i = v; LU_rd_i = a; LU_data_i = d;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    set_wb(1'b1, 5'd3, 32'h5);
    set_lu(1'b0, 5'd0, 32'd0);
    pend_rd_query_i = 5'd0;
    #3;
    checks++; if (RF_write_enable_o !== 1'b0) begin errors++; $display("FAIL reset_en got %b exp 0", RF_write_enable_o); end
    checks++; if (LU_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", LU_ready_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall_o); end
    checks++; if (pend_hit_o !== 1'b0) begin errors++; $display("FAIL reset_pend got %b exp 0", pend_hit_o); end
    set_wb(1'b0, 5'd0, 32'd0);
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_wb_only();
    set_wb(1'b1, 5'd5, 32'h1234);
    settle();
    checks++; if (RF_write_enable_o !== 1'b1) begin errors++; $display("FAIL wb_en got %b exp 1", RF_write_enable_o); end
    checks++; if (RF_write_address_o !== 5'd5) begin errors++; $display("FAIL wb_addr got %0d exp 5", RF_write_address_o); end
    checks++; if (RF_write_data_o !== 32'h1234) begin errors++; $display("FAIL wb_data got %h exp 1234", RF_write_data_o); end
    checks++; if (LU_ready_o !== 1'b1) begin errors++; $display("FAIL wb_ready got %b exp 1", LU_ready_o); end
    tick();
    set_wb(1'b0, 5'd0, 32'd0);
    settle();
    checks++; if (RF_write_enable_o !== 1'b0) begin errors++; $display("FAIL wb_idle_en got %b exp 0", RF_write_enable_o); end
    tick();
  endtask

  task automatic test_lu_idle();
    pend_rd_query_i = 5'd7;
    set_lu(1'b1, 5'd7, 32'hAAAA);
    settle();
    checks++; if (LU_ready_o !== 1'b1) begin errors++; $display("FAIL lu_ready got %b exp 1", LU_ready_o); end
    checks++; if (RF_write_enable_o !== 1'b0) begin errors++; $display("FAIL lu_no_passthru got %b exp 0", RF_write_enable_o); end
    checks++; if (pend_hit_o !== 1'b0) begin errors++; $display("FAIL lu_pend_c0 got %b exp 0", pend_hit_o); end
    tick();
    set_lu(1'b0, 5'd0, 32'd0);
    settle();
    checks++; if (RF_write_enable_o !== 1'b1) begin errors++; $display("FAIL lu_en got %b exp 1", RF_write_enable_o); end
    checks++; if (RF_write_address_o !== 5'd7) begin errors++; $display("FAIL lu_addr got %0d exp 7", RF_write_address_o); end
    checks++; if (RF_write_data_o !== 32'hAAAA) begin errors++; $display("FAIL lu_data got %h exp aaaa", RF_write_data_o); end
    checks++; if (pend_hit_o !== 1'b1) begin errors++; $display("FAIL lu_pend_c1 got %b exp 1", pend_hit_o); end
    tick();
    settle();
    checks++; if (pend_hit_o !== 1'b0) begin errors++; $display("FAIL lu_pend_c2 got %b exp 0", pend_hit_o); end
    checks++; if (RF_write_enable_o !== 1'b0) begin errors++; $display("FAIL lu_en_c2 got %b exp 0", RF_write_enable_o); end
    tick();
  endtask

  task automatic test_back_to_back();
    set_lu(1'b1, 5'd3, 32'h33);
    tick();
    set_lu(1'b1, 5'd4, 32'h44);
    settle();
    checks++; if (LU_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", LU_ready_o); end
    checks++; if (RF_write_enable_o !== 1'b1 || RF_write_address_o !== 5'd3 || RF_write_data_o !== 32'h33) begin
      errors++; $display("FAIL b2b_first got en=%b a=%0d d=%h exp en=1 a=3 d=33", RF_write_enable_o, RF_write_address_o, RF_write_data_o); end
    tick();
    set_lu(1'b0, 5'd0, 32'd0);
    settle();
    checks++; if (RF_write_enable_o !== 1'b1 || RF_write_address_o !== 5'd4 || RF_write_data_o !== 32'h44) begin
      errors++; $display("FAIL b2b_second got en=%b a=%0d d=%h exp en=1 a=4 d=44", RF_write_enable_o, RF_write_address_o, RF_write_data_o); end
    tick();
    settle();
    checks++; if (RF_write_enable_o !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", RF_write_enable_o); end
    tick();
  endtask

  task automatic test_fill_stall();
    // c0, c1: write-back busy, two LU results pushed
    set_wb(1'b1, 5'd1, 32'h11);
    set_lu(1'b1, 5'd10, 32'hA0);
    tick();
    set_wb(1'b1, 5'd2, 32'h22);
    set_lu(1'b1, 5'd11, 32'hB0);
    settle();
    checks++; if (RF_write_address_o !== 5'd2 || RF_write_enable_o !== 1'b1) begin
      errors++; $display("FAIL fill_wb_wins got en=%b a=%0d exp en=1 a=2", RF_write_enable_o, RF_write_address_o); end
    tick();
    // c2..c12: third LU result held off, head ages
    set_wb(1'b1, 5'd1, 32'h11);
    set_lu(1'b1, 5'd12, 32'hC0);
    pend_rd_query_i = 5'd10;
    for (int c = 2; c <= 12; c++) begin
      settle();
      checks++; if (LU_ready_o !== 1'b0) begin errors++; $display("FAIL fill_ready c%0d got %b exp 0", c, LU_ready_o); end
      if (c == 2) begin
        checks++; if (pend_hit_o !== 1'b1) begin errors++; $display("FAIL fill_pend10 got %b exp 1", pend_hit_o); end
      end
      if (c == 9) begin
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL stall_early got %b exp 0", stall_o); end
      end
      if (c == 10 || c == 12) begin
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL stall_c%0d got %b exp 1", c, stall_o); end
      end
      tick();
    end
    pend_rd_query_i = 5'd12;
    settle();
    checks++; if (pend_hit_o !== 1'b0) begin errors++; $display("FAIL held_pend12 got %b exp 0", pend_hit_o); end
    // c13: drain
    set_wb(1'b0, 5'd0, 32'd0);
    set_lu(1'b0, 5'd0, 32'd0);
    settle();
    checks++; if (RF_write_enable_o !== 1'b1 || RF_write_address_o !== 5'd10 || RF_write_data_o !== 32'hA0) begin
      errors++; $display("FAIL drain0 got en=%b a=%0d d=%h exp en=1 a=10 d=a0", RF_write_enable_o, RF_write_address_o, RF_write_data_o); end
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL drain0_stall got %b exp 1", stall_o); end
    tick();
    settle();
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL drain1_stall got %b exp 0", stall_o); end
    checks++; if (LU_ready_o !== 1'b1) begin errors++; $display("FAIL drain1_ready got %b exp 1", LU_ready_o); end
    checks++; if (RF_write_enable_o !== 1'b1 || RF_write_address_o !== 5'd11 || RF_write_data_o !== 32'hB0) begin
      errors++; $display("FAIL drain1 got en=%b a=%0d d=%h exp en=1 a=11 d=b0", RF_write_enable_o, RF_write_address_o, RF_write_data_o); end
    tick();
    settle();
    checks++; if (RF_write_enable_o !== 1'b0) begin errors++; $display("FAIL drain2_en got %b exp 0", RF_write_enable_o); end
    tick();
  endtask

  task automatic test_kill();
    pend_rd_query_i = 5'd9;
    set_lu(1'b1, 5'd9, 32'h1);
    tick();
    set_lu(1'b0, 5'd0, 32'd0);
    set_wb(1'b1, 5'd9, 32'h2);
    settle();
    checks++; if (pend_hit_o !== 1'b1) begin errors++; $display("FAIL kill_pend_before got %b exp 1", pend_hit_o); end
    checks++; if (RF_write_enable_o !== 1'b1 || RF_write_address_o !== 5'd9 || RF_write_data_o !== 32'h2) begin
      errors++; $display("FAIL kill_wb got en=%b a=%0d d=%h exp en=1 a=9 d=2", RF_write_enable_o, RF_write_address_o, RF_write_data_o); end
    tick();
    set_wb(1'b0, 5'd0, 32'd0);
    settle();
    checks++; if (RF_write_enable_o !== 1'b0) begin errors++; $display("FAIL kill_pop_en got %b exp 0", RF_write_enable_o); end
    checks++; if (pend_hit_o !== 1'b0) begin errors++; $display("FAIL kill_pend_after got %b exp 0", pend_hit_o); end
    tick();
    settle();
    checks++; if (RF_write_enable_o !== 1'b0) begin errors++; $display("FAIL kill_after_en got %b exp 0", RF_write_enable_o); end
    tick();
    // same-cycle accept and write-back to the same register
    pend_rd_query_i = 5'd13;
    set_lu(1'b1, 5'd13, 32'h77);
    set_wb(1'b1, 5'd13, 32'h88);
    tick();
    set_lu(1'b0, 5'd0, 32'd0);
    set_wb(1'b0, 5'd0, 32'd0);
    settle();
    checks++; if (RF_write_enable_o !== 1'b0) begin errors++; $display("FAIL kill_same_en got %b exp 0", RF_write_enable_o); end
    checks++; if (pend_hit_o !== 1'b0) begin errors++; $display("FAIL kill_same_pend got %b exp 0", pend_hit_o); end
    tick();
  endtask

  task automatic test_r0();
    pend_rd_query_i = 5'd0;
    set_lu(1'b1, 5'd0, 32'hFFFF);
    set_wb(1'b1, 5'd0, 32'hFFFF);
    for (int c = 0; c < 4; c++) begin
      settle();
      checks++; if (RF_write_enable_o !== 1'b0) begin errors++; $display("FAIL r0_en c%0d got %b exp 0", c, RF_write_enable_o); end
      checks++; if (LU_ready_o !== 1'b1) begin errors++; $display("FAIL r0_ready c%0d got %b exp 1", c, LU_ready_o); end
      tick();
    end
    set_lu(1'b0, 5'd0, 32'd0);
    set_wb(1'b0, 5'd0, 32'd0);
    settle();
    checks++; if (RF_write_enable_o !== 1'b0) begin errors++; $display("FAIL r0_after_en got %b exp 0", RF_write_enable_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    set_wb(1'b1, 5'd1, 32'h11);
    set_lu(1'b1, 5'd20, 32'h20);
    tick();
    set_lu(1'b1, 5'd21, 32'h21);
    tick();
    set_lu(1'b0, 5'd0, 32'd0);
    for (int c = 0; c < 10; c++) tick();
    pend_rd_query_i = 5'd20;
    settle();
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL mid_stall_pre got %b exp 1", stall_o); end
    checks++; if (pend_hit_o !== 1'b1) begin errors++; $display("FAIL mid_pend_pre got %b exp 1", pend_hit_o); end
    rst_i = 1'b1;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL mid_stall got %b exp 0", stall_o); end
    checks++; if (LU_ready_o !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", LU_ready_o); end
    checks++; if (RF_write_enable_o !== 1'b0) begin errors++; $display("FAIL mid_en got %b exp 0", RF_write_enable_o); end
    checks++; if (pend_hit_o !== 1'b0) begin errors++; $display("FAIL mid_pend got %b exp 0", pend_hit_o); end
    tick();
    rst_i = 1'b0;
    set_wb(1'b0, 5'd0, 32'd0);
    for (int c = 0; c < 4; c++) begin
      settle();
      checks++; if (RF_write_enable_o !== 1'b0) begin errors++; $display("FAIL mid_after_en c%0d got %b exp 0", c, RF_write_enable_o); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_wb_only();
    test_lu_idle();
    test_back_to_back();
    test_fill_stall();
    test_kill();
    test_r0();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
